debug_display: RTL

//  Downstream of the MIPS core's debug outputs. Consumes state, pc and data.

---
 rtl/debug_display.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/debug_display.sv
// debug_display: shows one of four debug views of the MIPS core (pc, data,
// state, or pc/data low halves) as 8 hex digits on a multiplexed active-low
// seven-segment display. A raw push button is synchronised, debounced and
// used to step through the views.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits in
// views 0-2 (digit 0 is always shown, view 3 is never blanked).
module debug_display #(
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [31:0] pc,
    input  logic [31:0] data,
    input  logic        btn_next,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  view
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // 32-bit word selected by the view index.
    function automatic logic [31:0] view_value(input logic [1:0] v,
                                               input logic [31:0] pc_v,
                                               input logic [31:0] data_v,
                                               input logic [3:0]  state_v);
        logic [31:0] w;
        case (v)
            2'd0:    w = pc_v;
            2'd1:    w = data_v;
            2'd2:    w = {28'h0, state_v};
            2'd3:    w = {pc_v[15:0], data_v[15:0]};
            default: w = pc_v;
        endcase
        return w;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Position of the most-significant non-zero nibble (0 when the word is 0).
    function automatic logic [2:0] top_nibble(input logic [31:0] w);
        logic [2:0] pos;
        pos = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w[4*i +: 4] != 4'h0) begin
                pos = 3'(i);
            end
        end
        return pos;
    endfunction
`endif

    logic             sync1_q, sync2_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic [1:0]       view_q, view_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_q, snap_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       nib_s;
    logic             blank_s;

    // State register: synchroniser, debouncer, view, scan counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            view_q        <= 2'd0;
            div_q         <= '0;
            idx_q         <= 3'd0;
            snap_q        <= 32'h0;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            sync1_q       <= btn_next;
            sync2_q       <= sync1_q;
            db_cnt_q      <= db_cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            view_q        <= view_d;
            div_q         <= div_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    // Next-state logic: debounce, view stepping, digit scan, snapshot and output decode.
    always_comb begin
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        view_d   = view_q;
        div_d    = div_q;
        idx_d    = idx_q;
        snap_d   = snap_q;
        blank_s  = 1'b0;

        // The level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end

        // Only the rising edge of the debounced level advances, so holding never repeats.
        if (stable_q && !stable_prev_q) begin
            view_d = view_q + 2'd1;
        end else begin
            view_d = view_q;
        end

        // Snapshot on the 7->0 digit wrap so a whole frame shows one coherent value.
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                snap_d = view_value(view_q, pc, data, state);
            end else begin
                snap_d = snap_q;
            end
        end else begin
            div_d  = div_q + DIV_W'(1);
            idx_d  = idx_q;
            snap_d = snap_q;
        end

        nib_s = 4'(snap_q >> {idx_q, 2'b00});

`ifdef LEADING_ZERO_BLANK_EN
        blank_s = (view_q != 2'd3) && (idx_q > top_nibble(snap_q));
`else
        blank_s = 1'b0;
`endif

        if (blank_s) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
        end else begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = hex7(nib_s);
        end
        // The decimal point separates the pc and data halves in view 3.
        dp_d = ~((view_q == 2'd3) && (idx_q == 3'd4));
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign view = view_q;

endmodule
